cmp_bank: RTL and testbench

CMP_BANK -- requirements
Module: cmp_bank

---
 rtl/cmp_bank.sv | 129 ++++++++++++
 tb/tb_cmp_bank.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmp_bank.sv
// cmp_bank -- two-stage register/immediate comparator feeding a bank of
// per-context {lt,gt,eq} flag registers.
//
// Stage 1 (E0): on start, operand A = regs[num1] and operand B (arg when
// num1 == num2, otherwise regs[num2]) are captured together with
// signed_mode and ctx. Stage 2 (E1): the captured compare is written into
// the flags of the captured context, and done pulses for one cycle.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start               compare request (at most one per cycle)
//   signed_mode         1 = two's-complement compare, 0 = unsigned
//   ctx                 destination flag context of the request
//   num1, num2          register selects for operands A and B
//   arg                 immediate used as B when num1 == num2
//   regs                flattened register file, reg i at [i*WIDTH +: WIDTH]
//   clr, clr_ctx        clear the flags of context clr_ctx
//   rd_ctx              context presented on lt/gt/eq
//   busy                a request sits in stage 2
//   done, done_ctx      one-cycle pulse after a flag write, with its context
//   lt, gt, eq          flags of context rd_ctx (combinational read)

// One flag context: holds {lt,gt,eq}. A write beats a clear in the same cycle.
module cmp_bank_ctx (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr,
    input  logic [2:0] wr_flags,
    input  logic       clr,
    output logic [2:0] flags
);
    always_ff @(posedge clk) begin
        if (rst)      flags <= 3'b000;
        else if (wr)  flags <= wr_flags;
        else if (clr) flags <= 3'b000;
    end
endmodule

module cmp_bank #(
    parameter int WIDTH = 16,
    parameter int NREG  = 4,
    parameter int NCTX  = 2,
    localparam int SELW = $clog2(NREG),
    localparam int CTXW = $clog2(NCTX)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  signed_mode,
    input  logic [CTXW-1:0]       ctx,
    input  logic [SELW-1:0]       num1,
    input  logic [SELW-1:0]       num2,
    input  logic [WIDTH-1:0]      arg,
    input  logic [NREG*WIDTH-1:0] regs,
    input  logic                  clr,
    input  logic [CTXW-1:0]       clr_ctx,
    input  logic [CTXW-1:0]       rd_ctx,
    output logic                  busy,
    output logic                  done,
    output logic [CTXW-1:0]       done_ctx,
    output logic                  lt,
    output logic                  gt,
    output logic                  eq
);
    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             sm;
        logic [CTXW-1:0]  ctx;
    } req_t;

    logic [NREG-1:0][WIDTH-1:0] rf;
    req_t                       req_in, s1;
    // vld_pipe[0]: request held in stage 1 (pending), vld_pipe[1]: done pulse
    logic [1:0]                 vld_pipe;
    logic [2:0]                 res;
    logic [2:0]                 bank [NCTX];

    assign rf = regs;

    always_comb begin
        req_in.a   = rf[num1];
        req_in.b   = (num1 == num2) ? arg : rf[num2];
        req_in.sm  = signed_mode;
        req_in.ctx = ctx;
    end

    // Operand/context capture; gated by start so idle cycles don't toggle it.
    always_ff @(posedge clk) begin
        if (rst)        s1 <= '0;
        else if (start) s1 <= req_in;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe <= 2'b00;
            done_ctx <= '0;
        end else begin
            vld_pipe <= {vld_pipe[0], start};
            if (vld_pipe[0]) done_ctx <= s1.ctx;
        end
    end

    // {lt,gt,eq}; exactly one bit is ever set.
    always_comb begin
        res = 3'b000;
        if (s1.a == s1.b)
            res = 3'b001;
        else if (s1.sm ? ($signed(s1.a) < $signed(s1.b)) : (s1.a < s1.b))
            res = 3'b100;
        else
            res = 3'b010;
    end

    for (genvar c = 0; c < NCTX; c++) begin : g_ctx
        cmp_bank_ctx u_ctx (
            .clk      (clk),
            .rst      (rst),
            .wr       (vld_pipe[0] && (s1.ctx == CTXW'(c))),
            .wr_flags (res),
            .clr      (clr && (clr_ctx == CTXW'(c))),
            .flags    (bank[c])
        );
    end

    assign busy         = vld_pipe[0];
    assign done         = vld_pipe[1];
    assign {lt, gt, eq} = bank[rd_ctx];
endmodule

// File: tb/tb_cmp_bank.sv
// Self-checking bench for cmp_bank: spec vector table, hand-written
// pipelining / clear-collision / reset sequences, then random traffic
// compared every cycle against a request-queue reference model.
module tb_cmp_bank;
    localparam int W    = 16;
    localparam int NREG = 4;
    localparam int NCTX = 2;
    localparam int SELW = $clog2(NREG);
    localparam int CTXW = $clog2(NCTX);

    logic                      clk = 1'b0;
    logic                      rst, start, signed_mode, clr;
    logic [CTXW-1:0]           ctx, clr_ctx, rd_ctx;
    logic [SELW-1:0]           num1, num2;
    logic [W-1:0]              arg;
    logic [NREG-1:0][W-1:0]    regs_a;
    logic                      busy, done, lt, gt, eq;
    logic [CTXW-1:0]           done_ctx;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cmp_bank #(.WIDTH(W), .NREG(NREG), .NCTX(NCTX)) dut (
        .clk(clk), .rst(rst), .start(start), .signed_mode(signed_mode),
        .ctx(ctx), .num1(num1), .num2(num2), .arg(arg), .regs(regs_a),
        .clr(clr), .clr_ctx(clr_ctx), .rd_ctx(rd_ctx),
        .busy(busy), .done(done), .done_ctx(done_ctx),
        .lt(lt), .gt(gt), .eq(eq)
    );

    // ---------------- reference model ----------------
    // A request's result is decided the moment it is accepted and then
    // travels through a queue; it lands in the bank one edge later.
    typedef struct {
        int         c;
        logic [2:0] f;
    } inflight_t;

    inflight_t  q[$];
    logic [2:0] mbank [NCTX];
    logic       mdone;
    int         mdone_ctx;

    function automatic logic [2:0] ref_flags(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic sm);
        longint va, vb;
        va = longint'(a);
        vb = longint'(b);
        if (sm && a[W-1]) va = va - (longint'(1) << W);
        if (sm && b[W-1]) vb = vb - (longint'(1) << W);
        return {va < vb, va > vb, va == vb};
    endfunction

    // Apply the inputs currently driven to the model (call just before an edge).
    task automatic model_step();
        inflight_t r;
        bit        wrote;
        int        wctx;
        logic [W-1:0] b;
        wrote = 0;
        wctx  = 0;
        if (rst) begin
            q.delete();
            for (int c = 0; c < NCTX; c++) mbank[c] = 3'b000;
            mdone     = 1'b0;
            mdone_ctx = 0;
        end else begin
            mdone = 1'b0;
            if (q.size() != 0) begin
                r = q.pop_front();
                mbank[r.c] = r.f;
                mdone      = 1'b1;
                mdone_ctx  = r.c;
                wrote      = 1;
                wctx       = r.c;
            end
            if (clr && !(wrote && wctx == int'(clr_ctx))) mbank[clr_ctx] = 3'b000;
            if (start) begin
                b   = (num1 == num2) ? arg : regs_a[num2];
                r.c = int'(ctx);
                r.f = ref_flags(regs_a[num1], b, signed_mode);
                q.push_back(r);
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_check();
        chk("model_busy", 32'(busy), 32'(q.size() != 0));
        chk("model_done", 32'(done), 32'(mdone));
        if (mdone) chk("model_done_ctx", 32'(done_ctx), 32'(mdone_ctx));
        chk("model_flags", 32'({lt, gt, eq}), 32'(mbank[rd_ctx]));
    endtask

    // One clock: update model from current inputs, take the edge, check #1 later.
    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        model_check();
    endtask

    task automatic idle();
        start = 0; clr = 0; rst = 0;
    endtask

    task automatic req(input logic sm, input int c, input int n1, input int n2,
                       input logic [W-1:0] v1, input logic [W-1:0] v2);
        start       = 1;
        signed_mode = sm;
        ctx         = CTXW'(c);
        num1        = SELW'(n1);
        num2        = SELW'(n2);
        regs_a[n1]  = v1;
        if (n1 == n2) arg = v2;
        else          regs_a[n2] = v2;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        string      name;
        logic       sm;
        int         n1, n2, c;
        logic [W-1:0] v1, v2;
        logic [2:0] exp;   // {lt,gt,eq}
    } vec_t;

    vec_t tbl[8];

    initial begin
        tbl[0] = '{"signed_m1_vs_1",   1'b1, 0, 1, 0, 16'hFFFF, 16'h0001, 3'b100};
        tbl[1] = '{"unsigned_ffff_1",  1'b0, 0, 1, 0, 16'hFFFF, 16'h0001, 3'b010};
        tbl[2] = '{"imm_equal",        1'b0, 2, 2, 0, 16'h0010, 16'h0010, 3'b001};
        tbl[3] = '{"imm_less",         1'b0, 2, 2, 0, 16'h0010, 16'h0011, 3'b100};
        tbl[4] = '{"signed_min_max",   1'b1, 3, 0, 1, 16'h8000, 16'h7FFF, 3'b100};
        tbl[5] = '{"unsigned_min_max", 1'b0, 3, 0, 1, 16'h8000, 16'h7FFF, 3'b010};
        tbl[6] = '{"signed_zero_eq",   1'b1, 1, 3, 1, 16'h0000, 16'h0000, 3'b001};
        tbl[7] = '{"signed_imm_gt",    1'b1, 1, 1, 0, 16'h0001, 16'hFFFE, 3'b010};

        rst = 1; start = 0; signed_mode = 0; ctx = 0; num1 = 0; num2 = 0;
        arg = 0; regs_a = '0; clr = 0; clr_ctx = 0; rd_ctx = 0;
        for (int c = 0; c < NCTX; c++) mbank[c] = 3'b000;
        mdone = 0; mdone_ctx = 0;

        // Reset state
        tick(); tick();
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_done_ctx", 32'(done_ctx), 0);
        for (int c = 0; c < NCTX; c++) begin
            rd_ctx = CTXW'(c); #1;
            chk("rst_flags", 32'({lt, gt, eq}), 0);
        end
        idle();

        // Table: one request, done exactly two edges later
        foreach (tbl[i]) begin
            req(tbl[i].sm, tbl[i].c, tbl[i].n1, tbl[i].n2, tbl[i].v1, tbl[i].v2);
            rd_ctx = CTXW'(tbl[i].c);
            tick();
            chk({tbl[i].name, "_busy"}, 32'(busy), 1);
            chk({tbl[i].name, "_early_done"}, 32'(done), 0);
            idle();
            regs_a = {$urandom, $urandom};   // must not affect captured operands
            arg    = W'($urandom);
            tick();
            chk({tbl[i].name, "_done"}, 32'(done), 1);
            chk({tbl[i].name, "_done_ctx"}, 32'(done_ctx), 32'(tbl[i].c));
            chk({tbl[i].name, "_flags"}, 32'({lt, gt, eq}), 32'(tbl[i].exp));
            tick();
            chk({tbl[i].name, "_done_pulse"}, 32'(done), 0);
        end

        // Back-to-back: ctx0 gt then ctx1 lt on consecutive cycles
        req(1'b0, 0, 0, 1, 16'd5, 16'd3);
        tick();
        req(1'b0, 1, 2, 3, 16'd3, 16'd5);
        tick();
        chk("b2b_done_a", 32'(done), 1);
        chk("b2b_ctx_a", 32'(done_ctx), 0);
        chk("b2b_busy", 32'(busy), 1);
        idle();
        tick();
        chk("b2b_done_b", 32'(done), 1);
        chk("b2b_ctx_b", 32'(done_ctx), 1);
        tick();
        chk("b2b_done_end", 32'(done), 0);
        rd_ctx = 0; #1;
        chk("b2b_flags0", 32'({lt, gt, eq}), 32'(3'b010));
        rd_ctx = 1; #1;
        chk("b2b_flags1", 32'({lt, gt, eq}), 32'(3'b100));

        // Clear collides with write to the same context: write wins
        req(1'b0, 1, 0, 1, 16'd7, 16'd7);
        tick();
        idle(); clr = 1; clr_ctx = 1;
        tick();
        clr = 0;
        rd_ctx = 1; #1;
        chk("clr_same_ctx", 32'({lt, gt, eq}), 32'(3'b001));
        // Clear ctx0 while ctx1 is written: both apply
        req(1'b0, 1, 0, 1, 16'd9, 16'd2);
        tick();
        idle(); clr = 1; clr_ctx = 0;
        tick();
        clr = 0;
        rd_ctx = 0; #1;
        chk("clr_other_ctx0", 32'({lt, gt, eq}), 0);
        rd_ctx = 1; #1;
        chk("clr_other_ctx1", 32'({lt, gt, eq}), 32'(3'b010));

        // Reset mid-operation: no done, busy low, all flags cleared
        req(1'b1, 0, 0, 1, 16'h0001, 16'h0002);
        tick();
        idle(); rst = 1;
        tick();
        chk("rst_mid_done", 32'(done), 0);
        chk("rst_mid_busy", 32'(busy), 0);
        rst = 0;
        tick();
        chk("rst_mid_nodone", 32'(done), 0);
        for (int c = 0; c < NCTX; c++) begin
            rd_ctx = CTXW'(c); #1;
            chk("rst_mid_flags", 32'({lt, gt, eq}), 0);
        end

        // start together with rst is ignored
        req(1'b0, 0, 0, 1, 16'd1, 16'd2);
        rst = 1;
        tick();
        idle();
        tick();
        chk("rst_start_busy", 32'(busy), 0);
        chk("rst_start_done", 32'(done), 0);

        // Random traffic against the model
        for (int n = 0; n < 2000; n++) begin
            rst         = ($urandom_range(0, 99) < 2);
            start       = ($urandom_range(0, 99) < 70);
            signed_mode = 1'($urandom);
            ctx         = CTXW'($urandom);
            num1        = SELW'($urandom);
            num2        = SELW'($urandom);
            regs_a      = {$urandom, $urandom};
            if ($urandom_range(0, 3) == 0) regs_a[num2] = regs_a[num1];
            arg         = ($urandom_range(0, 3) == 0) ? regs_a[num1] : W'($urandom);
            clr         = ($urandom_range(0, 99) < 20);
            clr_ctx     = CTXW'($urandom);
            rd_ctx      = CTXW'($urandom);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
